// File: rtl/brq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : brq_pkg                                                    |
// | Purpose : Shared defaults and helpers for the branch resolve queue.  |
// |           Holds the DEPTH/CNT_W defaults, the pointer-width constant |
// |           and a saturating-increment function used by the counters.  |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package brq_pkg;

   localparam int DEPTH_DEFAULT = 8;
   localparam int CNT_W_DEFAULT = 16;
   localparam int PTR_W_DEFAULT = $clog2(DEPTH_DEFAULT);

   // Increment a counter of 'width' bits (held zero-extended in 64 bits),
   // sticking at all-ones instead of wrapping.
   function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
      logic [63:0] max_val;
      max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      return (value >= max_val) ? value : value + 64'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : branch_resolve_queue_if                                    |
// | Purpose : Prediction/resolution handshake and status bundle of the   |
// |           branch resolve queue.                                      |
// | Ports   : master - issues predictions/resolutions, observes status   |
// |           slave  - the queue itself                                  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface branch_resolve_queue_if #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
);
   logic                     pred_valid;
   logic                     pred_taken;
   logic                     pred_ready;
   logic                     res_valid;
   logic                     res_taken;
   logic                     upd_valid;
   logic                     upd_taken;
   logic                     mispredict;
   logic                     orphan;
   logic [$clog2(DEPTH):0]   occupancy;
   logic [CNT_W-1:0]         resolve_cnt;
   logic [CNT_W-1:0]         mispred_cnt;

   modport master (
      output pred_valid, pred_taken, res_valid, res_taken,
      input  pred_ready, upd_valid, upd_taken, mispredict, orphan,
             occupancy, resolve_cnt, mispred_cnt
   );

   modport slave (
      input  pred_valid, pred_taken, res_valid, res_taken,
      output pred_ready, upd_valid, upd_taken, mispredict, orphan,
             occupancy, resolve_cnt, mispred_cnt
   );
endinterface
`default_nettype wire

// File: rtl/brq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : brq_fifo                                                   |
// | Purpose : In-order storage of 1-bit predictions with wrap-around     |
// |           pointers and a single-edge flush.                          |
// | Ports   : clk, rst      - clock, synchronous active-high reset       |
// |           push_i/din_i  - write din_i at the tail (pre-qualified)    |
// |           pop_i         - retire the head entry (pre-qualified)      |
// |           flush_i       - empty the queue, overriding push and pop   |
// |           head_o        - oldest stored prediction                   |
// |           occupancy_o   - number of entries held (registered)        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module brq_fifo
   import brq_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic                   din_i,
   output logic                   head_o,
   output logic [$clog2(DEPTH):0] occupancy_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   occ_q, occ_d;

   // DEPTH is a power of two, so the natural PTR_W-bit rollover is the
   // modulo-DEPTH wrap.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push_i && !pop_i)      occ_d = occ_q + 1'b1;
         else if (pop_i && !push_i) occ_d = occ_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage is deliberately unreset; an entry is only read after it has
   // been written since the last flush or reset.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   assign head_o      = mem_q[rd_ptr_q];
   assign occupancy_o = occ_q;

endmodule
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : branch_resolve_queue                                       |
// | Purpose : Tracks in-flight branch predictions, compares each against |
// |           its resolution, strobes predictor updates, flushes on a    |
// |           mispredict and keeps saturating statistics.                |
// | Ports   : clk, rst - clock, synchronous active-high reset            |
// |           bus      - slave side of branch_resolve_queue_if           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module branch_resolve_queue
   import brq_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   branch_resolve_queue_if.slave bus
);
   localparam int               OCC_W      = $clog2(DEPTH) + 1;
   localparam logic [OCC_W-1:0] c_occ_full = OCC_W'(DEPTH);

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_mispred;
   logic             w_head;
   logic [OCC_W-1:0] w_occupancy;

   logic             upd_valid_q,  upd_valid_d;
   logic             upd_taken_q,  upd_taken_d;
   logic             mispredict_q, mispredict_d;
   logic             orphan_q,     orphan_d;
   logic [CNT_W-1:0] resolve_cnt_q, resolve_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   // Full/empty come from registered occupancy only, so a pop in the same
   // cycle never frees a slot for a push.
   assign w_full    = (w_occupancy == c_occ_full);
   assign w_empty   = (w_occupancy == '0);
   assign w_push    = bus.pred_valid & ~w_full;
   assign w_pop     = bus.res_valid & ~w_empty;
   assign w_mispred = w_pop & (bus.res_taken ^ w_head);

   // A mispredict flushes the whole queue, including any same-cycle push.
   brq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (w_push),
      .pop_i       (w_pop),
      .flush_i     (w_mispred),
      .din_i       (bus.pred_taken),
      .head_o      (w_head),
      .occupancy_o (w_occupancy)
   );

   always_comb begin
      upd_valid_d   = w_pop;
      upd_taken_d   = w_pop & bus.res_taken;
      mispredict_d  = w_mispred;
      orphan_d      = bus.res_valid & w_empty;
      resolve_cnt_d = resolve_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (w_pop) begin
         resolve_cnt_d = CNT_W'(sat_inc(64'(resolve_cnt_q), CNT_W));
      end
      if (w_mispred) begin
         mispred_cnt_d = CNT_W'(sat_inc(64'(mispred_cnt_q), CNT_W));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         upd_valid_q   <= 1'b0;
         upd_taken_q   <= 1'b0;
         mispredict_q  <= 1'b0;
         orphan_q      <= 1'b0;
         resolve_cnt_q <= '0;
         mispred_cnt_q <= '0;
      end else begin
         upd_valid_q   <= upd_valid_d;
         upd_taken_q   <= upd_taken_d;
         mispredict_q  <= mispredict_d;
         orphan_q      <= orphan_d;
         resolve_cnt_q <= resolve_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign bus.pred_ready  = ~w_full;
   assign bus.upd_valid   = upd_valid_q;
   assign bus.upd_taken   = upd_taken_q;
   assign bus.mispredict  = mispredict_q;
   assign bus.orphan      = orphan_q;
   assign bus.occupancy   = w_occupancy;
   assign bus.resolve_cnt = resolve_cnt_q;
   assign bus.mispred_cnt = mispred_cnt_q;

endmodule
`default_nettype wire

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, in-flight prediction capacity, power of two, 2..64.
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port pred_valid, input, 1, a prediction was issued this cycle.
REQ-006 SHALL have port pred_taken, input, 1, predicted direction; qualified by pred_valid.
REQ-007 SHALL have port pred_ready, output, 1, queue not full.
REQ-008 SHALL have port res_valid, input, 1, the oldest outstanding branch resolved this cycle.
REQ-009 SHALL have port res_taken, input, 1, actual direction; qualified by res_valid.
REQ-010 SHALL have port upd_valid, output, 1, one-cycle update strobe to the predictor's result input.
REQ-011 SHALL have port upd_taken, output, 1, actual direction to the predictor's taken input; valid with upd_valid.
REQ-012 SHALL have port mispredict, output, 1, one-cycle pulse when the resolved direction differs from the queued prediction.
REQ-013 SHALL have port orphan, output, 1, one-cycle pulse when res_valid arrives with the queue empty.
REQ-014 SHALL have port occupancy, output, $clog2(DEPTH)+1, number of entries held.
REQ-015 SHALL have port resolve_cnt, output, CNT_W, count of accepted resolutions.
REQ-016 SHALL have port mispred_cnt, output, CNT_W, count of mispredictions.

Function
REQ-017 SHALL be an in-order FIFO of 1-bit predictions; push when pred_valid && pred_ready; pop when res_valid && occupancy!=0.
REQ-018 SHALL drive pred_ready = (occupancy != DEPTH) combinationally from registered state only.
REQ-019 SHALL reject pushes while full; a pop in that same cycle does not make the push accepted.
REQ-020 SHALL, for an accepted pop, drive upd_valid=1, upd_taken=res_taken, mispredict=(res_taken != head entry) exactly one cycle later, each for exactly one cycle.
REQ-021 SHALL, on res_valid with an empty queue, pulse orphan one cycle later, with upd_valid=0 and no counter change; a same-cycle push is still accepted.
REQ-022 SHALL, on a mispredicting pop, flush the queue in that same edge: occupancy becomes 0, both pointers equal, and any same-cycle push is discarded.
REQ-023 SHALL, on a simultaneous push and non-mispredicting pop, keep occupancy unchanged and advance both pointers.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL increment resolve_cnt on every accepted pop and mispred_cnt on every mispredicting pop; both saturate at all-ones and never wrap.
REQ-026 SHALL register all outputs except pred_ready.

Reset
REQ-027 SHALL, while rst=1, clear both pointers, occupancy, resolve_cnt, mispred_cnt, upd_valid, upd_taken, mispredict and orphan to 0; pred_ready reads 1 the cycle after.
REQ-028 SHALL let rst override a same-cycle push or pop; in-flight entries are discarded and no update strobe follows.
REQ-029 SHALL leave entry storage contents unreset; they are unobservable while occupancy=0.

Structure
REQ-030 SHALL place the DEPTH and CNT_W defaults, the pointer-width constant and a saturating-increment function in package brq_pkg.
REQ-031 SHALL implement the storage and pointers as one sub-module brq_fifo, which provides a flush input; the compare, strobe and counter logic stay in the top level.

Verification
REQ-032 Scenario: push T,N,T; resolve T,N,T -> upd_valid 3 pulses with upd_taken 1,0,1; mispredict never set; resolve_cnt=3; occupancy=0.
REQ-033 Scenario: push 8 entries with DEPTH=8 -> pred_ready=0; 9th push ignored; one pop -> pred_ready=1 the next cycle; occupancy=7.
REQ-034 Scenario: push T,T,T; resolve N -> mispredict pulse; upd_taken=0; occupancy=0 the next cycle; mispred_cnt=1.
REQ-035 Scenario: queue empty, res_valid=1 and pred_valid=1 with pred_taken=1 in the same cycle -> orphan pulse, upd_valid=0, occupancy=1.
REQ-036 Scenario: CNT_W=2, 5 mispredicting single-entry cycles -> mispred_cnt reads 3 and holds.
REQ-037 Scenario: occupancy=4, rst asserted with res_valid=1 -> no upd_valid pulse; all counters and occupancy read 0.
